// File: rtl/jtoutrun_fb_pkg.sv
// jtoutrun_fb_pkg: shared constants for the Out Run framebuffer writer.
// Holds drain FSM encodings, the default frame size and word-packing layout.
package jtoutrun_fb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [15:0] MAXW_DEF = 16'd35840;

   localparam int HW_W     = 16;
   localparam int PIX0_LSB = 0;
   localparam int PIX1_LSB = 16;

   // Second pixel of a pair lands in the upper half-word.
   function automatic logic [31:0] pack_word(
      input logic [HW_W-1:0] h1,
      input logic [HW_W-1:0] h0
   );
      return {h1, h0};
   endfunction

endpackage

// File: rtl/jtoutrun_fb_writer_if.sv
// jtoutrun_fb_writer_if: jtframe-style cs/ok SDRAM write slot.
// The writer owns cs/addr/data; the SDRAM controller answers with ok.
interface jtoutrun_fb_writer_if #(parameter int AW = 17);

   logic          fb_cs;
   logic [AW-1:0] fb_addr;
   logic [31:0]   fb_data;
   logic          fb_ok;

   modport master (
      output fb_cs, fb_addr, fb_data,
      input  fb_ok
   );

   modport slave (
      input  fb_cs, fb_addr, fb_data,
      output fb_ok
   );

endinterface

// File: rtl/jtoutrun_fb_fifo.sv
// jtoutrun_fb_fifo: small synchronous FIFO carrying {address, data} words.
// A push while full is dropped; push and pop may share a cycle.
module jtoutrun_fb_fifo #(
   parameter int DW = 49,
   parameter int AW = 3
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wp, rp;
   logic          do_push, do_pop;

   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) &&
                    (wp[AW-1:0] == rp[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop)  rp <= rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/jtoutrun_fb_writer.sv
// jtoutrun_fb_writer: packs RGB555 pixels two per word into a double-buffered SDRAM frame.
// Define JTOUTRUN_FB_SHADOW_EN to add a shadow input stored in bit 15 of each half-word.
module jtoutrun_fb_writer
   import jtoutrun_fb_pkg::*;
#(
   parameter int          FIFO_AW = 3,
   parameter int          AW      = 17,
   parameter logic [15:0] MAXW    = MAXW_DEF
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pxl_cen,
   input  logic       enable,
   input  logic       LHBL,
   input  logic       LVBL,
   input  logic [4:0] red,
   input  logic [4:0] green,
   input  logic [4:0] blue,
`ifdef JTOUTRUN_FB_SHADOW_EN
   input  logic       shadow,
`endif
   jtoutrun_fb_writer_if.master fb,
   output logic       disp_bank,
   output logic       frame_done,
   output logic       overflow
);

   localparam int            CW   = AW - 1;
   localparam int            FW   = 32 + AW;
   localparam logic [CW-1:0] MAXC = CW'(MAXW);

   logic          lvbl_l, lhbl_l, active, eof_pend, wr_bank;
   logic          has0, sh0, sh;
   logic [14:0]   pix0, pix;
   logic [CW-1:0] word_cnt;
   logic [1:0]    st;
   logic          vs_rise, vs_fall, hs_fall, sample;
   logic          push_try, in_rng, push, pop;
   logic          full, empty, swap;
   logic [31:0]   push_word;
   logic [FW-1:0] fifo_out;

`ifdef JTOUTRUN_FB_SHADOW_EN
   assign sh = shadow;
`else
   assign sh = 1'b0;
`endif

   assign pix      = {red, green, blue};
   assign vs_rise  = LVBL & ~lvbl_l;
   assign vs_fall  = ~LVBL & lvbl_l;
   assign hs_fall  = ~LHBL & lhbl_l;
   assign sample   = pxl_cen & LHBL & LVBL & active;
   assign push_try = has0 & (sample | hs_fall);
   assign in_rng   = word_cnt < MAXC;
   assign push     = push_try & in_rng & ~full;
   assign pop      = (st == ST_REQ) & fb.fb_ok;

   // A line ending on an odd pixel is flushed with an empty upper half.
   assign push_word = sample ?
      pack_word({sh, pix}, {sh0, pix0}) :
      pack_word(16'd0, {sh0, pix0});

   // A new frame start forces a pending bank swap to complete first.
   assign swap = eof_pend &
      ((empty & (st == ST_IDLE)) | vs_rise);

   jtoutrun_fb_fifo #(
      .DW (FW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({wr_bank, word_cnt, push_word}),
      .pop   (pop),
      .dout  (fifo_out),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lvbl_l     <= 1'b1;
         lhbl_l     <= 1'b1;
         active     <= 1'b0;
         eof_pend   <= 1'b0;
         wr_bank    <= 1'b0;
         disp_bank  <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         has0       <= 1'b0;
         sh0        <= 1'b0;
         pix0       <= '0;
         word_cnt   <= '0;
      end else begin
         lvbl_l     <= LVBL;
         lhbl_l     <= LHBL;
         frame_done <= swap;
         if (swap) begin
            disp_bank <= wr_bank;
            wr_bank   <= ~wr_bank;
            eof_pend  <= 1'b0;
         end else if (vs_fall & active) begin
            eof_pend <= 1'b1;
         end
         if (vs_rise) begin
            active   <= enable;
            word_cnt <= '0;
            overflow <= 1'b0;
            has0     <= 1'b0;
         end else begin
            // Dropped words still consume an address slot.
            if (push_try & in_rng) begin
               word_cnt <= word_cnt + CW'(1);
               if (full) overflow <= 1'b1;
            end
            if (sample) begin
               has0 <= ~has0;
               pix0 <= pix;
               sh0  <= sh;
            end else if (hs_fall) begin
               has0 <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= ST_IDLE;
         fb.fb_cs   <= 1'b0;
         fb.fb_addr <= '0;
         fb.fb_data <= '0;
      end else begin
         case (st)
            ST_IDLE: if (!empty) begin
               st         <= ST_REQ;
               fb.fb_cs   <= 1'b1;
               fb.fb_addr <= fifo_out[FW-1:32];
               fb.fb_data <= fifo_out[31:0];
            end
            ST_REQ: if (fb.fb_ok) begin
               st       <= ST_GAP;
               fb.fb_cs <= 1'b0;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtoutrun_fb_writer.sv
// tb_jtoutrun_fb_writer: random frames checked against a word-level framebuffer model.
// Covers packing, odd-width flush, saturation, overflow, bank swap, enable and reset.
module tb_jtoutrun_fb_writer;

   localparam int          AW   = 17;
   localparam logic [15:0] MAXW = 16'd60;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pxl_cen = 1'b0;
   logic       enable = 1'b0;
   logic       LHBL = 1'b0;
   logic       LVBL = 1'b0;
   logic [4:0] red = '0, green = '0, blue = '0;
   logic       disp_bank, frame_done, overflow;

   jtoutrun_fb_writer_if #(.AW(AW)) fb();

   jtoutrun_fb_writer #(
      .FIFO_AW (3),
      .AW      (AW),
      .MAXW    (MAXW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pxl_cen    (pxl_cen),
      .enable     (enable),
      .LHBL       (LHBL),
      .LVBL       (LVBL),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .fb         (fb),
      .disp_bank  (disp_bank),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_err = 0;
   int          wr_cnt = 0, fd_cnt = 0, cs_cyc = 0;
   int          ok_dly = 0, kick_req = 0;
   bit          hold_ok = 1'b0;
   int          last_addr = 0;
   logic [31:0] last_data = '0;
   logic [31:0] exp_mem [int];
   logic [14:0] line_pix [$];
   bit          model_bank = 1'b0;
   bit          exp_disp = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // SDRAM slot model: checks each write against the expected frame image.
   task automatic responder();
      int kick_done;
      int a;
      kick_done = 0;
      fb.fb_ok = 1'b0;
      forever begin
         tick();
         if (kick_req != kick_done) begin
            kick_done = kick_req;
            fb.fb_ok = 1'b1;
            tick();
            fb.fb_ok = 1'b0;
         end else if (fb.fb_cs && !hold_ok) begin
            a = int'(fb.fb_addr);
            wr_cnt++;
            last_addr = a;
            last_data = fb.fb_data;
            chk("wr_addr_known", 32'(exp_mem.exists(a)), 1);
            if (exp_mem.exists(a)) begin
               chk("wr_data", fb.fb_data, exp_mem[a]);
               exp_mem.delete(a);
            end
            repeat (ok_dly) begin
               tick();
               chk("req_hold", {fb.fb_cs, fb.fb_addr},
                   {1'b1, a[AW-1:0]});
            end
            fb.fb_ok = 1'b1;
            tick();
            fb.fb_ok = 1'b0;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (frame_done) fd_cnt++;
         if (fb.fb_cs) cs_cyc++;
      end
   endtask

   task automatic run_frame(input int w, input int h,
                            input bit en, input int div,
                            input bit ovf);
      logic [14:0] p [$];
      logic [14:0] a0, a1;
      int n, nexp, wr0, fd0, cs0, key, drop, wn;
      bit bank;
      bank = model_bank;
      n = 0;
      nexp = 0;
      for (int i = 0; i < w * h; i++) begin
         if (line_pix.size() != 0) p.push_back(line_pix[i % w]);
         else p.push_back(15'($urandom));
      end
      if (en) begin
         for (int y = 0; y < h; y++) begin
            for (int k = 0; k < (w + 1) / 2; k++) begin
               a0 = p[y*w + 2*k];
               a1 = (2*k + 1 < w) ? p[y*w + 2*k + 1] : 15'd0;
               if (n < int'(MAXW)) begin
                  key = (int'(bank) << (AW-1)) + n;
                  exp_mem[key] = {1'b0, a1, 1'b0, a0};
                  nexp++;
               end
               n++;
            end
         end
      end
      wr0 = wr_cnt;
      fd0 = fd_cnt;
      cs0 = cs_cyc;
      if (ovf) hold_ok = 1'b1;
      enable = en;
      LHBL = 1'b0;
      LVBL = 1'b1;
      repeat (4) tick();
      chk("ovf_clear_at_start", overflow, 0);
      for (int y = 0; y < h; y++) begin
         LHBL = 1'b1;
         tick();
         for (int x = 0; x < w; x++) begin
            {red, green, blue} = p[y*w + x];
            pxl_cen = 1'b1;
            tick();
            pxl_cen = 1'b0;
            if (ovf && y == 0 && (x % 2) == 1) begin
               wn = (x + 1) / 2;
               if (wn == 8) chk("ovf_after_8", overflow, 0);
               if (wn == 9) chk("ovf_after_9", overflow, 1);
            end
            repeat (div - 1) tick();
         end
         LHBL = 1'b0;
         repeat (8) tick();
         if (ovf && y == 0) hold_ok = 1'b0;
      end
      LVBL = 1'b0;
      if (en) begin
         for (int t = 0; t < 800 && fd_cnt == fd0; t++) tick();
         repeat (10) tick();
         chk("frame_done_once", fd_cnt - fd0, 1);
         chk("disp_bank", disp_bank, bank);
         if (ovf) begin
            drop = w / 2 - 8;
            chk("ovf_sticky", overflow, 1);
            chk("ovf_wr_count", wr_cnt - wr0, nexp - drop);
            chk("ovf_dropped", exp_mem.size(), drop);
            exp_mem.delete();
         end else begin
            chk("wr_count", wr_cnt - wr0, nexp);
            chk("unwritten", exp_mem.size(), 0);
         end
         exp_disp = bank;
         model_bank = ~model_bank;
      end else begin
         repeat (60) tick();
         chk("dis_no_writes", wr_cnt - wr0, 0);
         chk("dis_no_cs", cs_cyc - cs0, 0);
         chk("dis_no_done", fd_cnt - fd0, 0);
         chk("dis_bank_hold", disp_bank, exp_disp);
      end
   endtask

   task automatic rand_frame();
      line_pix.delete();
      ok_dly = $urandom_range(0, 2);
      run_frame($urandom_range(1, 24), $urandom_range(1, 8),
                1'b1, $urandom_range(3, 5), 1'b0);
   endtask

   initial begin
      int c0, fd0;
      fork
         responder();
         monitor();
      join_none
      repeat (3) tick();
      chk("rst_cs", fb.fb_cs, 0);
      chk("rst_addr", fb.fb_addr, 0);
      chk("rst_data", fb.fb_data, 0);
      chk("rst_disp_bank", disp_bank, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      repeat (3) tick();

      ok_dly = 2;
      line_pix = '{15'h7C00, 15'h001F};
      run_frame(2, 1, 1'b1, 4, 1'b0);
      chk("pair_word", last_data, 32'h001F_7C00);
      chk("pair_addr", last_addr, 0);

      line_pix = '{15'h1234, 15'h0ABC, 15'h7FFF,
                   15'h0001, 15'h5555};
      run_frame(5, 1, 1'b1, 4, 1'b0);
      chk("odd_flush_hi", 32'(last_data[31:16]), 0);
      chk("bank1_addr", last_addr, 32'h1_0002);

      repeat (6) rand_frame();

      line_pix.delete();
      ok_dly = 0;
      run_frame(32, 2, 1'b1, 4, 1'b1);
      rand_frame();

      line_pix.delete();
      run_frame(12, 3, 1'b0, 4, 1'b0);
      rand_frame();

      hold_ok = 1'b1;
      enable = 1'b1;
      LHBL = 1'b0;
      LVBL = 1'b1;
      repeat (3) tick();
      LHBL = 1'b1;
      tick();
      repeat (2) begin
         {red, green, blue} = 15'($urandom);
         pxl_cen = 1'b1;
         tick();
         pxl_cen = 1'b0;
         tick();
      end
      LHBL = 1'b0;
      for (int t = 0; t < 50 && !fb.fb_cs; t++) tick();
      chk("cs_before_rst", fb.fb_cs, 1);
      fd0 = fd_cnt;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_cs", fb.fb_cs, 0);
      chk("mid_rst_addr", fb.fb_addr, 0);
      chk("mid_rst_data", fb.fb_data, 0);
      chk("mid_rst_disp", disp_bank, 0);
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_ovf", overflow, 0);
      c0 = cs_cyc;
      kick_req++;
      repeat (10) tick();
      chk("late_ok_ignored", cs_cyc - c0, 0);
      hold_ok = 1'b0;
      LVBL = 1'b0;
      repeat (30) tick();
      chk("rst_no_done", fd_cnt - fd0, 0);
      exp_mem.delete();
      model_bank = 1'b0;
      exp_disp = 1'b0;

      rand_frame();
      rand_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
